// File: rtl/frame_gen_pkg.sv
// rtl/frame_gen_pkg.sv - shared types and constants for the frame generator run control
//
// Purpose: sequencer state encoding, control-word bit positions, default core geometry
//          and a helper that builds the core control word.
// Ports:   none (package).

package frame_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        GAP,
        DONE
    } seq_state_e;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_RESET_BIT  = 1;

    localparam int WIDTH               = 1920;
    localparam int HEIGHT              = 1080;
    localparam int NUMPIXELPLANES      = 3;
    localparam int DEFAULT_FRAME_BEATS = WIDTH * HEIGHT * NUMPIXELPLANES;

    // Control word with all reserved bits [31:2] forced to zero.
    function automatic logic [31:0] ctrl_word(input logic enable, input logic soft_reset);
        logic [31:0] w;
        w                  = '0;
        w[CTRL_ENABLE_BIT] = enable;
        w[CTRL_RESET_BIT]  = soft_reset;
        return w;
    endfunction

endpackage

// File: rtl/frame_gen_down_counter.sv
// rtl/frame_gen_down_counter.sv - loadable down counter with zero flag
//
// Purpose: cycle timer shared by the soft-reset hold and the inter-frame gap.
//          A load has priority over a decrement; the count stops at zero.
// Ports:
//   clk        in   1  clock
//   reset      in   1  async, active-low reset
//   load       in   1  load load_value this cycle
//   load_value in   W  value to load
//   dec        in   1  decrement (ignored when already zero)
//   zero       out  1  count is zero

module frame_gen_down_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frame_gen_sequencer.sv
// rtl/frame_gen_sequencer.sv - run-control sequencer for the frame generator core
//
// Purpose: turns host start/stop commands plus frame count and inter-frame gap into the
//          core control word (bit0 enable, bit1 soft reset) and TLAST period, counting
//          core advances so every run ends exactly on a frame boundary.
// Ports:
//   clk              in   1      clock
//   reset            in   1      async, active-low reset
//   cmd_start        in   1      pulse: begin a run (only from IDLE or DONE)
//   cmd_stop         in   1      pulse: stop at the next frame boundary
//   cfg_frames       in   CNT_W  frames per run, 0 = free-run
//   cfg_gap          in   CNT_W  enable-low cycles between frames
//   cfg_last_period  in   32     core TLAST period, latched at start
//   core_ready       in   1      core dataOutReady
//   core_control     out  32     core controlRegister
//   core_last_period out  32     latched TLAST period
//   busy             out  1      run in progress (CLEAR/RUN/GAP)
//   done_pulse       out  1      one cycle on entry to DONE
//   frames_done      out  CNT_W  frames completed in current/last run
//   beat_count       out  32     advances within the current frame

module frame_gen_sequencer
    import frame_gen_pkg::*;
#(
    parameter int FRAME_BEATS  = DEFAULT_FRAME_BEATS,
    parameter int CLEAR_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [31:0]      cfg_last_period,
    input  logic             core_ready,
    output logic [31:0]      core_control,
    output logic [31:0]      core_last_period,
    output logic             busy,
    output logic             done_pulse,
    output logic [CNT_W-1:0] frames_done,
    output logic [31:0]      beat_count
);

    localparam logic [31:0]      LAST_BEAT  = 32'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [31:0]      CTRL_HOLD  = 32'h2;
    localparam logic [31:0]      CTRL_RUN   = 32'h1;
    localparam logic [31:0]      CTRL_OFF   = 32'h0;

    seq_state_e       state_q, state_d;
    logic [31:0]      control_q, control_d;
    logic [31:0]      last_period_q, last_period_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [31:0]      beat_q, beat_d;
    logic [CNT_W-1:0] cfg_frames_q, cfg_frames_d;
    logic [CNT_W-1:0] cfg_gap_q, cfg_gap_d;
    logic             stop_req_q, stop_req_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_dec;
    logic             timer_zero;

    // The core steps its pixel state exactly when enabled and ready; that is what we count.
    logic             advance;
    logic             frame_end;
    logic             last_frame;
    logic [CNT_W-1:0] frames_inc;

    assign advance    = control_q[CTRL_ENABLE_BIT] && core_ready;
    assign frame_end  = (state_q == RUN) && advance && (beat_q == LAST_BEAT);
    assign frames_inc = (frames_q == '1) ? frames_q : frames_q + CNT_W'(1);
    // Compared against the pre-increment count so the decision is made on the wrap edge.
    assign last_frame = (cfg_frames_q != '0) && ((frames_q + CNT_W'(1)) == cfg_frames_q);

    frame_gen_down_counter #(
        .W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            control_q     <= CTRL_HOLD;
            last_period_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frames_q      <= '0;
            beat_q        <= '0;
            cfg_frames_q  <= '0;
            cfg_gap_q     <= '0;
            stop_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            control_q     <= control_d;
            last_period_q <= last_period_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frames_q      <= frames_d;
            beat_q        <= beat_d;
            cfg_frames_q  <= cfg_frames_d;
            cfg_gap_q     <= cfg_gap_d;
            stop_req_q    <= stop_req_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        control_d     = control_q;
        last_period_d = last_period_q;
        frames_d      = frames_q;
        beat_d        = beat_q;
        cfg_frames_d  = cfg_frames_q;
        cfg_gap_d     = cfg_gap_q;
        stop_req_d    = stop_req_q;
        timer_load    = 1'b0;
        timer_value   = CLEAR_LOAD;
        timer_dec     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                control_d = (state_q == IDLE) ? CTRL_HOLD : CTRL_OFF;
                if (cmd_start) begin
                    state_d       = CLEAR;
                    control_d     = CTRL_HOLD;
                    last_period_d = cfg_last_period;
                    cfg_frames_d  = cfg_frames;
                    cfg_gap_d     = cfg_gap;
                    frames_d      = '0;
                    beat_d        = '0;
                    // A stop arriving with the start limits the run to one frame.
                    stop_req_d    = cmd_stop;
                    timer_load    = 1'b1;
                    timer_value   = CLEAR_LOAD;
                end
            end

            CLEAR: begin
                if (cmd_stop) begin
                    stop_req_d = 1'b1;
                    state_d    = DONE;
                    control_d  = CTRL_OFF;
                end else if (timer_zero) begin
                    state_d   = RUN;
                    control_d = CTRL_RUN;
                    beat_d    = '0;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            RUN: begin
                if (cmd_stop) begin
                    stop_req_d = 1'b1;
                end
                if (advance) begin
                    if (frame_end) begin
                        beat_d   = '0;
                        frames_d = frames_inc;
                        // Enable drops on the wrap edge itself so no extra beat leaks out.
                        if (stop_req_q || cmd_stop || last_frame) begin
                            state_d   = DONE;
                            control_d = CTRL_OFF;
                        end else if (cfg_gap_q != '0) begin
                            state_d     = GAP;
                            control_d   = CTRL_OFF;
                            timer_load  = 1'b1;
                            timer_value = cfg_gap_q - CNT_W'(1);
                        end else begin
                            control_d = CTRL_RUN;
                        end
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end

            GAP: begin
                // No soft reset here: the frame ended on the core's own wrap point.
                if (cmd_stop) begin
                    stop_req_d = 1'b1;
                    state_d    = DONE;
                    control_d  = CTRL_OFF;
                end else if (timer_zero) begin
                    state_d   = RUN;
                    control_d = CTRL_RUN;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                control_d = CTRL_HOLD;
            end
        endcase
    end

    assign busy_d = (state_d == CLEAR) || (state_d == RUN) || (state_d == GAP);
    assign done_d = (state_d == DONE) && (state_q != DONE);

    assign core_control     = control_q;
    assign core_last_period = last_period_q;
    assign busy             = busy_q;
    assign done_pulse       = done_q;
    assign frames_done      = frames_q;
    assign beat_count       = beat_q;

endmodule

// File: tb/tb_frame_gen_sequencer.sv
// tb/tb_frame_gen_sequencer.sv - scoreboard bench for frame_gen_sequencer

module tb_frame_gen_sequencer;

    localparam int FB = 12;
    localparam int CC = 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic          cmd_stop;
    logic [CW-1:0] cfg_frames;
    logic [CW-1:0] cfg_gap;
    logic [31:0]   cfg_last_period;
    logic          core_ready;
    logic [31:0]   core_control;
    logic [31:0]   core_last_period;
    logic          busy;
    logic          done_pulse;
    logic [CW-1:0] frames_done;
    logic [31:0]   beat_count;

    frame_gen_sequencer #(
        .FRAME_BEATS  (FB),
        .CLEAR_CYCLES (CC),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_start        (cmd_start),
        .cmd_stop         (cmd_stop),
        .cfg_frames       (cfg_frames),
        .cfg_gap          (cfg_gap),
        .cfg_last_period  (cfg_last_period),
        .core_ready       (core_ready),
        .core_control     (core_control),
        .core_last_period (core_last_period),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .frames_done      (frames_done),
        .beat_count       (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          frames;
        int          advances;
        int          gap;
        logic [31:0] last_period;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   run_adv    = 0;
    int   ready_mode = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Ready driver: always high, or a fair coin each cycle.
    initial begin
        core_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            core_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: counts advances from the interface and checks against the queued expectations.
    initial begin
        int   clr_run;
        int   gap_run;
        logic prev_done;
        exp_t e;
        clr_run   = 0;
        gap_run   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run_adv   = 0;
                clr_run   = 0;
                gap_run   = 0;
                prev_done = 1'b0;
            end else begin
                check("ctrl_reserved", core_control[31:2], 0);
                check("beat_count", beat_count, run_adv % FB);
                if (busy) check("frames_done_run", frames_done, run_adv / FB);

                if (busy && core_control == 32'h2) begin
                    clr_run++;
                end else begin
                    if (clr_run > 0 && busy && core_control == 32'h1) check("clear_len", clr_run, CC);
                    clr_run = 0;
                end

                if (busy && core_control == 32'h0) begin
                    gap_run++;
                end else begin
                    if (gap_run > 0 && busy && core_control == 32'h1 && exp_q.size() > 0)
                        check("gap_len", gap_run, exp_q[0].gap);
                    gap_run = 0;
                end

                if (done_pulse) begin
                    check("done_single", prev_done, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frames_done", frames_done, e.frames);
                        check("advances", run_adv, e.advances);
                        check("last_period", core_last_period, e.last_period);
                        check("done_busy", busy, 0);
                        check("done_control", core_control, 0);
                    end
                    run_adv = 0;
                end
                prev_done = done_pulse;

                if (core_control[0] && core_ready) run_adv++;
            end
        end
    end

    task automatic start_run(input int frames, input int gap, input logic [31:0] lp,
                             input bit with_stop, input bit push, input int exp_frames);
        exp_t e;
        @(posedge clk);
        #1;
        cfg_frames      = CW'(frames);
        cfg_gap         = CW'(gap);
        cfg_last_period = lp;
        cmd_start       = 1'b1;
        cmd_stop        = with_stop;
        if (push) begin
            e.frames      = exp_frames;
            e.advances    = exp_frames * FB;
            e.gap         = gap;
            e.last_period = lp;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_start       = 1'b0;
        cmd_stop        = 1'b0;
        // Configuration changes after the start must not affect the run.
        cfg_frames      = $urandom;
        cfg_gap         = $urandom;
        cfg_last_period = $urandom;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_timeout"}, n >= 2000, 0);
    endtask

    task automatic wait_adv(input int target);
        int n;
        n = 0;
        while (run_adv < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("wait_adv_timeout", n >= 500, 0);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int fr;
        int gp;
        cmd_start       = 1'b0;
        cmd_stop        = 1'b0;
        cfg_frames      = '0;
        cfg_gap         = '0;
        cfg_last_period = '0;
        reset           = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_control", core_control, 32'h2);
        check("rst_last_period", core_last_period, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_pulse, 0);
        check("rst_frames", frames_done, 0);
        check("rst_beat", beat_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: two frames back-to-back, ready always high.
        ready_mode = 0;
        start_run(2, 0, 32'h0000_1234, 1'b0, 1'b1, 2);
        wait_drain("t1");

        // 2: one frame, gap set, ready toggling.
        ready_mode = 1;
        start_run(1, 3, 32'h0000_0777, 1'b0, 1'b1, 1);
        wait_drain("t2");

        // 3: three frames with a 5-cycle gap.
        ready_mode = 0;
        start_run(3, 5, 32'hABCD_0001, 1'b0, 1'b1, 3);
        wait_drain("t3");

        // 4: free-run, stop at beat 5 of frame 2.
        ready_mode = 1;
        start_run(0, 0, 32'h0000_0042, 1'b0, 1'b1, 2);
        wait_adv(FB + 5);
        cmd_stop = 1'b1;
        @(posedge clk);
        #1;
        cmd_stop = 1'b0;
        wait_drain("t4");

        // 5a: stop during the gap ends the run on the next cycle.
        ready_mode = 0;
        start_run(3, 6, 32'h0000_0099, 1'b0, 1'b1, 1);
        n = 0;
        while (!(busy && core_control == 32'h0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5a_gap_timeout", n >= 200, 0);
        cmd_stop = 1'b1;
        @(posedge clk);
        #1;
        cmd_stop = 1'b0;
        check("t5a_done_next", done_pulse, 1);
        check("t5a_busy", busy, 0);
        wait_drain("t5a");

        // 5b: a start while busy is ignored.
        ready_mode = 1;
        start_run(2, 2, 32'h0000_5555, 1'b0, 1'b1, 2);
        wait_adv(3);
        start_run(5, 1, 32'hFFFF_0000, 1'b0, 1'b0, 0);
        wait_drain("t5b");

        // 5c: start and stop together from IDLE give one frame.
        apply_reset();
        ready_mode = 0;
        start_run(3, 2, 32'h0000_0C0C, 1'b1, 1'b1, 1);
        wait_drain("t5c");

        // 6: async reset mid-run at beat 7, then a clean run.
        ready_mode = 1;
        start_run(1, 0, 32'h0000_0707, 1'b0, 1'b0, 0);
        wait_adv(7);
        reset = 1'b0;
        #1;
        check("t6_async_control", core_control, 32'h2);
        check("t6_async_busy", busy, 0);
        check("t6_async_beat", beat_count, 0);
        check("t6_async_frames", frames_done, 0);
        check("t6_async_last_period", core_last_period, 0);
        @(negedge clk);
        check("t6_hold_control", core_control, 32'h2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        start_run(1, 0, 32'h0000_0808, 1'b0, 1'b1, 1);
        wait_drain("t6");

        // Random runs.
        for (int i = 0; i < 8; i++) begin
            fr         = $urandom_range(1, 3);
            gp         = $urandom_range(0, 4);
            ready_mode = $urandom_range(0, 1);
            start_run(fr, gp, $urandom, 1'b0, 1'b1, fr);
            wait_drain("rand");
        end

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
